// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, sync/blank decode.
// Ports: clk, rst_n in; x_crd, y_crd, hsync, vsync, video_on, pix_tick, frame_start out.
// Build option: define VGA_OUT_REG_EN to register every output except pix_tick.
module vga_timing_gen #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x_crd,
  output logic [9:0] y_crd,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic hs_c, vs_c, von_c, fs_c;

  // Gated by rst_n so the tick is low in reset even when PIX_DIV is 1.
  assign tick   = rst_n & (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + DW'(1);
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  always_comb begin
    hs_c  = ~((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_c  = ~((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    von_c = (h_cnt_q < H_ACT) & (v_cnt_q < V_ACT) & rst_n;
    fs_c  = tick & h_wrap & v_wrap;
  end

  assign pix_tick = tick;

`ifdef VGA_OUT_REG_EN
  logic [9:0] x_crd_q, x_crd_d;
  logic [9:0] y_crd_q, y_crd_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    x_crd_d       = h_cnt_q;
    y_crd_d       = v_cnt_q;
    hsync_d       = hs_c;
    vsync_d       = vs_c;
    video_on_d    = von_c;
    frame_start_d = fs_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_crd_q       <= '0;
      y_crd_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_crd_q       <= x_crd_d;
      y_crd_q       <= y_crd_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x_crd       = x_crd_q;
  assign y_crd       = y_crd_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
`else
  assign x_crd       = h_cnt_q;
  assign y_crd       = v_cnt_q;
  assign hsync       = hs_c;
  assign vsync       = vs_c;
  assign video_on    = von_c;
  assign frame_start = fs_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-geometry instance vs table and model,
// plus default and PIX_DIV=1 instances measured for sync timing.
module tb_vga_timing_gen;

`ifdef VGA_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  // small geometry: 15 px/line, 8 lines/frame, 4 clk/px -> 480 clk/frame
  localparam int SPD = 4;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fs;
  } out_t;

  typedef struct {
    int   n;
    out_t e;
  } vec_t;

  localparam out_t RV = '{10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] s_x, s_y, d_x, d_y, p_x, p_y;
  logic s_hs, s_vs, s_von, s_pt, s_fs;
  logic d_hs, d_vs, d_von, d_pt, d_fs;
  logic p_hs, p_vs, p_von, p_pt, p_fs;

  vga_timing_gen #(
    .PIX_DIV(SPD), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_crd(s_x), .y_crd(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pix_tick(s_pt), .frame_start(s_fs)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .x_crd(d_x), .y_crd(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pix_tick(d_pt), .frame_start(d_fs)
  );

  vga_timing_gen #(.PIX_DIV(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .x_crd(p_x), .y_crd(p_y),
    .hsync(p_hs), .vsync(p_vs), .video_on(p_von),
    .pix_tick(p_pt), .frame_start(p_fs)
  );

  out_t so, dobs, pobs;
  assign so   = {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_fs};
  assign dobs = {d_x, d_y, d_hs, d_vs, d_von, d_pt, d_fs};
  assign pobs = {p_x, p_y, p_hs, p_vs, p_von, p_pt, p_fs};

  int vecs = 0;
  int errs = 0;

  // Expected small-instance outputs n clock edges after reset release.
  function automatic out_t model(int n);
    out_t r;
    int m, p, h, v;
    r    = RV;
    r.pt = ((n % SPD) == SPD - 1);
    if (n >= LAT) begin
      m     = n - LAT;
      p     = (m / SPD) % (SHT * SVT);
      h     = p % SHT;
      v     = p / SHT;
      r.x   = 10'(h);
      r.y   = 10'(v);
      r.hs  = !(h >= SHA + SHF && h < SHA + SHF + SHS);
      r.vs  = !(v >= SVA + SVF && v < SVA + SVF + SVS);
      r.von = (h < SHA) && (v < SVA);
      r.fs  = ((m % SPD) == SPD - 1) && (p == SHT * SVT - 1);
    end
    return r;
  endfunction

  task automatic chk(string nm, out_t a, out_t e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
               nm, a.x, a.y, a.hs, a.vs, a.von, a.pt, a.fs,
               e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fs);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    vecs++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", nm, a, e);
    end
  endtask

  vec_t tbl[17];
  out_t lg[600];

  initial begin
    int n;
    int df1, df2, dr1, dvon;
    int pf1, pf2, pr1, pzero;
    logic dprev, pprev;
    out_t a;

    // n, {x, y, hs, vs, von, pt, fs} in the unregistered time base
    tbl[0]  = '{0,   '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[1]  = '{3,   '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[2]  = '{4,   '{10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[3]  = '{31,  '{10'd7,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[4]  = '{32,  '{10'd8,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{40,  '{10'd10, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{51,  '{10'd12, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[7]  = '{52,  '{10'd13, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{59,  '{10'd14, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[9]  = '{60,  '{10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[10] = '{240, '{10'd0,  10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[11] = '{300, '{10'd0,  10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[12] = '{419, '{10'd14, 10'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[13] = '{420, '{10'd0,  10'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[14] = '{479, '{10'd14, 10'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}};
    tbl[15] = '{480, '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[16] = '{483, '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}};

    // reset state on all instances
    repeat (3) @(posedge clk);
    #1;
    chk("rst_small", so, RV);
    chk("rst_default", dobs, RV);
    chk("rst_div1", pobs, RV);

    // release and log / measure
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    lg[0] = so;
    df1 = -1; df2 = -1; dr1 = -1; dvon = 0;
    pf1 = -1; pf2 = -1; pr1 = -1; pzero = 0;
    dprev = d_hs; pprev = p_hs;
    if (d_von) dvon++;
    if (!p_pt) pzero++;
    for (int k = 1; k <= 6000; k++) begin
      @(posedge clk);
      #1;
      if (k < 600) lg[k] = so;
      if (dprev && !d_hs) begin
        if (df1 < 0) df1 = k;
        else if (df2 < 0) df2 = k;
      end
      if (!dprev && d_hs && df1 >= 0 && dr1 < 0) dr1 = k;
      if (pprev && !p_hs) begin
        if (pf1 < 0) pf1 = k;
        else if (pf2 < 0) pf2 = k;
      end
      if (!pprev && p_hs && pf1 >= 0 && pr1 < 0) pr1 = k;
      if (k < 3200 && d_von) dvon++;
      if (!p_pt) pzero++;
      dprev = d_hs;
      pprev = p_hs;
    end

    chk_int("first_hsync_fall", df1, 2624 + LAT);
    chk_int("hsync_period", df2 - df1, 3200);
    chk_int("hsync_low_width", dr1 - df1, 384);
    chk_int("video_on_line0", dvon, 2560);
    chk_int("div1_first_fall", pf1, 656 + LAT);
    chk_int("div1_period", pf2 - pf1, 800);
    chk_int("div1_low_width", pr1 - pf1, 96);
    chk_int("div1_tick_const", pzero, 0);

    // table vectors against the log
    for (int i = 0; i < 17; i++) begin
      a    = lg[tbl[i].n + LAT];
      a.pt = lg[tbl[i].n].pt;
      chk($sformatf("tbl%0d_n%0d", i, tbl[i].n), a, tbl[i].e);
    end

    // random run lengths with asynchronous mid-frame resets
    for (int r = 0; r < 10; r++) begin
      rst_n = 1'b0;
      #1;
      chk("async_rst", so, RV);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      chk("rst_hold", so, RV);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      #1;
      chk("restart", so, model(0));
      repeat ($urandom_range(40, 1200)) begin
        @(posedge clk);
        #1;
        n++;
        chk("run", so, model(n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter PIX_DIV, default 4, giving clk cycles per pixel (100 MHz to 25 MHz).
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, all in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, all in lines.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port x_crd, output, 10 bits: current horizontal pixel count.
REQ-007 SHALL have port y_crd, output, 10 bits: current line count.
REQ-008 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-009 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-010 SHALL have port video_on, output, 1 bit: high while in the visible 640x480 area.
REQ-011 SHALL have port pix_tick, output, 1 bit: one-clk pulse at each pixel advance.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clk pulse when the frame wraps to (0,0).

Function
REQ-013 SHALL run a divider counter div_cnt from 0 to PIX_DIV-1, then wrap to 0.
REQ-014 SHALL drive pix_tick high when div_cnt == PIX_DIV-1; if PIX_DIV == 1, pix_tick is constant 1 out of reset.
REQ-015 SHALL hold the horizontal counter h_cnt (10 bit) and the vertical counter v_cnt (10 bit) unchanged on cycles without pix_tick.
REQ-016 SHALL, on pix_tick, increment h_cnt; at H_TOTAL-1 (799) h_cnt wraps to 0 and v_cnt advances.
REQ-017 SHALL, when v_cnt advances at V_TOTAL-1 (524), wrap v_cnt to 0; h_cnt and v_cnt wrap on the same edge.
REQ-018 SHALL compute H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; all compares are unsigned 10-bit.
REQ-019 SHALL drive x_crd = h_cnt and y_crd = v_cnt, including in blanking; no saturation.
REQ-020 SHALL drive hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751, and high otherwise.
REQ-021 SHALL drive vsync low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, and high otherwise.
REQ-022 SHALL drive video_on = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE) & rst_n.
REQ-023 SHALL drive frame_start high for exactly one clk: the pix_tick cycle where h_cnt == 799 and v_cnt == 524.
REQ-024 SHALL make hsync and vsync pure decodes of the counters, so no glitch-free guarantee is made beyond synchronous outputs.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously clear div_cnt, h_cnt and v_cnt to 0.
REQ-026 SHALL, while rst_n is low, hold x_crd 0, y_crd 0, hsync 1, vsync 1, video_on 0, pix_tick 0 and frame_start 0.
REQ-027 SHALL restart timing from (0,0) when reset is asserted mid-frame; no partial frame_start is emitted.
REQ-028 SHALL, after rst_n deasserts, produce the first pix_tick on the PIX_DIV-th rising clk edge.

Configuration
REQ-029 SHALL, with VGA_OUT_REG_EN defined, pass x_crd, y_crd, hsync, vsync, video_on and frame_start through one output register stage.
REQ-030 SHALL, with VGA_OUT_REG_EN defined, give those outputs one extra clk of latency (relative alignment kept) and apply the REQ-026 values as register reset values.
REQ-031 SHALL, without VGA_OUT_REG_EN, drive those outputs combinationally from the counters; pix_tick is never delayed in either build.

Verification
REQ-032 SHALL cover line and frame periods: default params, free run -> hsync falling edges exactly 3200 clks apart; vsync falling edges exactly 1,680,000 clks apart.
REQ-033 SHALL cover sync widths: measure low pulses -> hsync low 384 clks; vsync low 6400 clks; video_on high 2560 clks per visible line and 0 on lines 480..524.
REQ-034 SHALL cover the first sync after reset: release rst_n -> first hsync fall 2624 clk edges after release (2625 with VGA_OUT_REG_EN).
REQ-035 SHALL cover the frame wrap: at h=799, v=524 -> frame_start one-clk pulse, x_crd/y_crd go to 0/0 on the next pix_tick, and exactly one frame_start per frame.
REQ-036 SHALL cover mid-frame reset: assert rst_n low at h=300, v=200 -> outputs immediately (async) show the REQ-026 values; after release, counting resumes from 0,0.
REQ-037 SHALL cover PIX_DIV=1: pix_tick constant 1 -> line period 800 clks, hsync low 96 clks.
